stopwatch_lap_cnt: RTL and testbench
====================================

Name: stopwatch_lap_cnt

Overview:
- Next-generation stopwatch counter chain: sub-second, second, minute and hour digits with parametrised moduli.
- Adds run/stop gating, up/down (countdown timer) mode, preset load and a lap-capture FIFO.
- Sits between the 100 Hz pulse generator and the display/button-control logic, replacing the fixed three-stage up-only counter.

Parameters:
- SUB_MAX, 100, sub-second modulus (count 0..SUB_MAX-1)
- SEC_MAX, 60, seconds modulus
- MIN_MAX, 60, minutes modulus
- HR_MAX, 24, hours modulus
- LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  clear; acts on rising edge
- plsi  in  1  100 Hz pulse; one count per falling edge
- run  in  1  level; 1 = counting enabled
- mode  in  1  0 = count up, 1 = count down
- load  in  1  level; 1 = load preset this cycle
- ld_sub/ld_sec/ld_min/ld_hr  in  clog2(each MAX)  preset values
- lap  in  1  capture current time; acts on rising edge
- lap_rd  in  1  pop FIFO head (1-cycle pulse)
- usec/sec/min/hr  out  clog2(each MAX)  live count
- lap_sub/lap_sec/lap_min/lap_hr  out  same widths  FIFO head (first-word fall-through)
- lap_empty, lap_full  out  1  FIFO status
- lap_ovf  out  1  sticky: a capture was dropped
- done  out  1  sticky: countdown reached zero
- ovf  out  1  one-cycle pulse on up-count wrap

Behaviour:
- Reset: all counts 0, FIFO empty, lap_empty=1, lap_full=0, lap_ovf=0, done=0, ovf=0. Edge-detect registers are cleared, so the first cycle after reset sees no edges.
- Edge detection:
  - plsi_d, clr_d and lap_d are registered copies of their inputs.
  - tick = plsi_d & ~plsi; clr_e = clr & ~clr_d; lap_e = lap & ~lap_d.
  - Counters update on the same clock edge that sees tick; outputs change one cycle after plsi is sampled low.
- Priority each cycle: rst > clr_e > load > tick.
  - clr_e clears counts, FIFO, lap_ovf, done and ovf.
  - load writes the presets. Any preset >= its MAX saturates to MAX-1. load also clears done.
- Counting:
  - A tick is counted only when run=1, and in down mode only when done=0.
  - Up: sub increments. A carry ripples through the digits in the same cycle: sub wraps at SUB_MAX-1 -> 0 and carries to sec, and so on.
  - Up wrap from (HR_MAX-1:59:59.99) -> all zero and ovf=1 for one cycle.
  - Down: sub decrements. A borrow ripples: 0 -> MAX-1 and borrows from the next digit.
  - Down, when the tick brings the count to all-zero: done is set on that same edge. Further ticks are ignored.
  - Down starting already at all-zero: a tick sets done and the count stays 0.
- Lap FIFO:
  - lap_e pushes the counter values registered before this cycle's update. On a simultaneous tick, the pre-tick time is captured.
  - Push while full (with no pop in the same cycle): entry is dropped and lap_ovf is set.
  - Push and pop in the same cycle: both happen, including when full; occupancy is unchanged.
  - Pop while empty is ignored.
  - lap_* outputs show the head entry; they are 0 when empty.
  - Pointers are clog2(LAP_DEPTH)+1 bits. full = MSBs differ and lower bits equal.
  - lap and lap_rd are honoured regardless of run.
- A tick with run=0 is lost, not deferred.
- A mode change takes effect on the next tick. clr held high gives one clear only.

Decomposition:
- Package stopwatch_pkg: default moduli constants, a clog2-based width function, and a lap-record struct typedef {sub, sec, min, hr}.
- Sub-module stopwatch_digit: one mod-N up/down digit with inputs clr, load, ld_val, en, dir; outputs q, co (carry or borrow out, combinational).
  - It is instantiated four times and chained via co -> en.
- The FIFO stays inline.

Test Plan:
- Reset, run=1, mode=0, 100 plsi falling edges -> usec=0, sec=1. At 6000 edges -> min=1, sec=0.
- Load 23:59:59.99, one tick -> all zero, ovf high exactly one cycle.
- mode=1, load 00:00:01.00, 100 ticks -> all zero with done=1 on the 100th. 5 more ticks -> unchanged.
- lap rising edge on the same cycle as a tick at 00:00:00.41 -> FIFO head 00:00:00.41, live usec=42.
- 5 lap edges with LAP_DEPTH=4 -> lap_full=1, lap_ovf=1, first four entries pop in order, then lap_empty=1.
- run=0 with 10 ticks -> no change. clr rising edge mid-count -> counts, FIFO, done, lap_ovf all 0 next cycle. load+clr together -> clear wins.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants, width helper and lap record for the stopwatch counter chain.
package stopwatch_pkg;

  localparam int unsigned SubMaxDef   = 100;
  localparam int unsigned SecMaxDef   = 60;
  localparam int unsigned MinMaxDef   = 60;
  localparam int unsigned HrMaxDef    = 24;
  localparam int unsigned LapDepthDef = 4;

  // Lap record fields are wide enough for any modulus up to 256.
  localparam int unsigned LapFieldW = 8;

  function automatic int unsigned sw_width(input int unsigned max);
    return (max <= 2) ? 1 : $clog2(max);
  endfunction

  typedef struct packed {
    logic [LapFieldW-1:0] sub;
    logic [LapFieldW-1:0] sec;
    logic [LapFieldW-1:0] min;
    logic [LapFieldW-1:0] hr;
  } lap_rec_t;

endpackage

// File: rtl/stopwatch_digit.sv
// One mod-MAX up/down digit; co flags a carry (up) or borrow (down) into the next digit.
module stopwatch_digit import stopwatch_pkg::*; #(
  parameter int unsigned MAX = 10,
  localparam int unsigned W = sw_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] q,
  output logic         co
);

  localparam logic [W-1:0] Top = W'(MAX - 1);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (32'(ld_val) >= MAX) ? Top : ld_val;
    end else if (en) begin
      if (dir) q_d = (q_q == '0) ? Top : q_q - W'(1);
      else     q_d = (q_q == Top) ? '0 : q_q + W'(1);
    end
  end

  assign co = en & (dir ? (q_q == '0) : (q_q == Top));
  assign q  = q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/stopwatch_lap_cnt.sv
// Stopwatch counter chain with run/stop, countdown mode, preset load and a lap-capture FIFO.
module stopwatch_lap_cnt import stopwatch_pkg::*; #(
  parameter int unsigned SUB_MAX   = SubMaxDef,
  parameter int unsigned SEC_MAX   = SecMaxDef,
  parameter int unsigned MIN_MAX   = MinMaxDef,
  parameter int unsigned HR_MAX    = HrMaxDef,
  parameter int unsigned LAP_DEPTH = LapDepthDef
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         plsi,
  input  logic                         run,
  input  logic                         mode,
  input  logic                         load,
  input  logic [sw_width(SUB_MAX)-1:0] ld_sub,
  input  logic [sw_width(SEC_MAX)-1:0] ld_sec,
  input  logic [sw_width(MIN_MAX)-1:0] ld_min,
  input  logic [sw_width(HR_MAX)-1:0]  ld_hr,
  input  logic                         lap,
  input  logic                         lap_rd,
  output logic [sw_width(SUB_MAX)-1:0] usec,
  output logic [sw_width(SEC_MAX)-1:0] sec,
  output logic [sw_width(MIN_MAX)-1:0] min,
  output logic [sw_width(HR_MAX)-1:0]  hr,
  output logic [sw_width(SUB_MAX)-1:0] lap_sub,
  output logic [sw_width(SEC_MAX)-1:0] lap_sec,
  output logic [sw_width(MIN_MAX)-1:0] lap_min,
  output logic [sw_width(HR_MAX)-1:0]  lap_hr,
  output logic                         lap_empty,
  output logic                         lap_full,
  output logic                         lap_ovf,
  output logic                         done,
  output logic                         ovf
);

  localparam int unsigned SubW = sw_width(SUB_MAX);
  localparam int unsigned SecW = sw_width(SEC_MAX);
  localparam int unsigned MinW = sw_width(MIN_MAX);
  localparam int unsigned HrW  = sw_width(HR_MAX);
  localparam int unsigned AW   = $clog2(LAP_DEPTH);
  localparam int unsigned PW   = AW + 1;

  logic plsi_dly_q, clr_dly_q, lap_dly_q;
  logic tick, clr_e, lap_e;

  assign tick  = plsi_dly_q & ~plsi;
  assign clr_e = clr & ~clr_dly_q;
  assign lap_e = lap & ~lap_dly_q;

  logic [SubW-1:0] sub_q;
  logic [SecW-1:0] sec_q;
  logic [MinW-1:0] min_q;
  logic [HrW-1:0]  hr_q;
  logic            sub_co, sec_co, min_co, hr_co;
  logic            all_zero, is_one, cnt_en, dig_en;
  logic            done_d, done_q, ovf_d, ovf_q, lap_ovf_d, lap_ovf_q;

  always_comb begin
    all_zero = (sub_q == '0) && (sec_q == '0) && (min_q == '0) && (hr_q == '0);
    is_one   = (sub_q == SubW'(1)) && (sec_q == '0) && (min_q == '0) && (hr_q == '0);
    cnt_en   = tick & run & ~(mode & done_q);
    // A countdown sitting at zero must not borrow around to the maximum.
    dig_en   = cnt_en & ~(mode & all_zero);
  end

  stopwatch_digit #(.MAX(SUB_MAX)) u_sub (
    .clk(clk), .rst(rst), .clr(clr_e), .load(load), .ld_val(ld_sub),
    .en(dig_en), .dir(mode), .q(sub_q), .co(sub_co)
  );
  stopwatch_digit #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .clr(clr_e), .load(load), .ld_val(ld_sec),
    .en(sub_co), .dir(mode), .q(sec_q), .co(sec_co)
  );
  stopwatch_digit #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .clr(clr_e), .load(load), .ld_val(ld_min),
    .en(sec_co), .dir(mode), .q(min_q), .co(min_co)
  );
  stopwatch_digit #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst(rst), .clr(clr_e), .load(load), .ld_val(ld_hr),
    .en(min_co), .dir(mode), .q(hr_q), .co(hr_co)
  );

  logic [PW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic          fifo_empty, fifo_full, push, pop, drop;
  lap_rec_t      mem_q [LAP_DEPTH];
  lap_rec_t      cur_rec, head_rec;
  logic          unused_head;

  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop        = lap_rd & ~fifo_empty & ~clr_e;
    push       = lap_e & ~clr_e & (~fifo_full | pop);
    drop       = lap_e & ~clr_e & fifo_full & ~pop;
    wptr_d     = clr_e ? '0 : wptr_q + PW'(push);
    rptr_d     = clr_e ? '0 : rptr_q + PW'(pop);
  end

  // Capture uses the registered time, i.e. the value before this cycle's tick.
  always_comb begin
    cur_rec                = '0;
    cur_rec.sub[SubW-1:0]  = sub_q;
    cur_rec.sec[SecW-1:0]  = sec_q;
    cur_rec.min[MinW-1:0]  = min_q;
    cur_rec.hr[HrW-1:0]    = hr_q;
  end

  assign head_rec    = mem_q[rptr_q[AW-1:0]];
  assign unused_head = ^head_rec;

  always_comb begin
    done_d    = done_q;
    ovf_d     = 1'b0;
    lap_ovf_d = lap_ovf_q;
    if (clr_e) begin
      done_d    = 1'b0;
      lap_ovf_d = 1'b0;
    end else begin
      if (load) done_d = 1'b0;
      else if (cnt_en && mode && (all_zero || is_one)) done_d = 1'b1;
      if (!load && !mode && hr_co) ovf_d = 1'b1;
      if (drop) lap_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plsi_dly_q <= 1'b0;
      clr_dly_q  <= 1'b0;
      lap_dly_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      lap_ovf_q  <= 1'b0;
    end else begin
      plsi_dly_q <= plsi;
      clr_dly_q  <= clr;
      lap_dly_q  <= lap;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      lap_ovf_q  <= lap_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= cur_rec;
  end

  assign usec      = sub_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign hr        = hr_q;
  assign lap_sub   = fifo_empty ? '0 : head_rec.sub[SubW-1:0];
  assign lap_sec   = fifo_empty ? '0 : head_rec.sec[SecW-1:0];
  assign lap_min   = fifo_empty ? '0 : head_rec.min[MinW-1:0];
  assign lap_hr    = fifo_empty ? '0 : head_rec.hr[HrW-1:0];
  assign lap_empty = fifo_empty;
  assign lap_full  = fifo_full;
  assign lap_ovf   = lap_ovf_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_cnt.sv
// Directed bench for stopwatch_lap_cnt with default moduli (100/60/60/24) and a 4-deep lap FIFO.
module tb_stopwatch_lap_cnt;

  logic       clk = 1'b0;
  logic       rst, clr, plsi, run, mode, load, lap, lap_rd;
  logic [6:0] ld_sub, usec, lap_sub;
  logic [5:0] ld_sec, ld_min, sec, min, lap_sec, lap_min;
  logic [4:0] ld_hr, hr, lap_hr;
  logic       lap_empty, lap_full, lap_ovf, done, ovf;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_lap_cnt dut (
    .clk(clk), .rst(rst), .clr(clr), .plsi(plsi), .run(run), .mode(mode), .load(load),
    .ld_sub(ld_sub), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr),
    .lap(lap), .lap_rd(lap_rd),
    .usec(usec), .sec(sec), .min(min), .hr(hr),
    .lap_sub(lap_sub), .lap_sec(lap_sec), .lap_min(lap_min), .lap_hr(lap_hr),
    .lap_empty(lap_empty), .lap_full(lap_full), .lap_ovf(lap_ovf), .done(done), .ovf(ovf)
  );

  // Time encoded as HHMMSSCC decimal for compact expected values.
  function automatic int unsigned now_t();
    return hr * 1000000 + min * 10000 + sec * 100 + usec;
  endfunction

  function automatic int unsigned lap_t();
    return lap_hr * 1000000 + lap_min * 10000 + lap_sec * 100 + lap_sub;
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full plsi pulse; returns on the negedge after the counting edge.
  task automatic do_tick();
    @(negedge clk) plsi = 1'b1;
    @(negedge clk) plsi = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ticks(input int unsigned n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_load(input int unsigned h, input int unsigned m, input int unsigned s,
                         input int unsigned c);
    @(negedge clk);
    ld_hr = 5'(h); ld_min = 6'(m); ld_sec = 6'(s); ld_sub = 7'(c);
    load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic do_lap();
    @(negedge clk) lap = 1'b1;
    @(negedge clk) lap = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge clk) lap_rd = 1'b1;
    @(negedge clk) lap_rd = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; plsi = 1'b0; run = 1'b0; mode = 1'b0; load = 1'b0;
    lap = 1'b0; lap_rd = 1'b0; ld_sub = '0; ld_sec = '0; ld_min = '0; ld_hr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_time", now_t(), 0);
    check("reset_empty", lap_empty, 1);
    check("reset_full", lap_full, 0);
    check("reset_flags", {lap_ovf, done, ovf}, 0);

    // Up counting with carry into seconds and minutes
    run = 1'b1;
    do_ticks(100);
    check("up_100", now_t(), 100);
    do_ticks(5900);
    check("up_6000", now_t(), 10000);
    check("up_no_ovf", ovf, 0);

    // Saturating preset, then full wrap
    do_load(31, 63, 63, 127);
    check("load_sat", now_t(), 23595999);
    do_tick();
    check("wrap_time", now_t(), 0);
    check("wrap_ovf_hi", ovf, 1);
    @(negedge clk);
    check("wrap_ovf_lo", ovf, 0);

    // Countdown from one second
    mode = 1'b1;
    do_load(0, 0, 1, 0);
    do_ticks(99);
    check("down_99", now_t(), 1);
    check("down_99_done", done, 0);
    do_tick();
    check("down_100", now_t(), 0);
    check("down_100_done", done, 1);
    do_ticks(5);
    check("down_hold", now_t(), 0);
    check("down_hold_done", done, 1);

    // Countdown starting at zero
    do_clr();
    check("clr_done", done, 0);
    do_tick();
    check("down_zero_time", now_t(), 0);
    check("down_zero_done", done, 1);

    // Lap capture coincident with a tick
    mode = 1'b0;
    do_clr();
    do_ticks(41);
    check("pre_lap", now_t(), 41);
    @(negedge clk) plsi = 1'b1;
    @(negedge clk) begin plsi = 1'b0; lap = 1'b1; end
    @(negedge clk) lap = 1'b0;
    check("lap_head", lap_t(), 41);
    check("lap_live", now_t(), 42);
    check("lap_nonempty", lap_empty, 0);
    do_pop();
    check("lap_pop_empty", lap_empty, 1);
    check("lap_empty_zero", lap_t(), 0);

    // Five captures into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      do_tick();
      do_lap();
    end
    check("fifo_full", lap_full, 1);
    check("fifo_ovf", lap_ovf, 1);
    check("fifo_live", now_t(), 47);
    // Simultaneous push and pop while full
    @(negedge clk) begin lap = 1'b1; lap_rd = 1'b1; end
    @(negedge clk) begin lap = 1'b0; lap_rd = 1'b0; end
    check("pushpop_full", lap_full, 1);
    for (int i = 0; i < 4; i++) begin
      check("fifo_order", lap_t(), 44 + i);
      do_pop();
    end
    check("fifo_drained", lap_empty, 1);
    do_pop();
    check("pop_empty_ignored", lap_empty, 1);

    // Ticks while stopped are lost
    run = 1'b0;
    do_ticks(10);
    check("stopped", now_t(), 47);

    // Clear mid-count, held high clears only once
    run = 1'b1;
    do_lap();
    check("pre_clr_lap", lap_empty, 0);
    @(negedge clk) clr = 1'b1;
    @(negedge clk);
    check("clr_time", now_t(), 0);
    check("clr_fifo", lap_empty, 1);
    check("clr_flags", {lap_ovf, done}, 0);
    do_tick();
    check("clr_held_count", now_t(), 1);

    // Load and clear together: clear wins
    @(negedge clk) clr = 1'b0;
    @(negedge clk) begin
      clr = 1'b1; load = 1'b1; ld_hr = 5'd0; ld_min = 6'd0; ld_sec = 6'd5; ld_sub = 7'd0;
    end
    @(negedge clk) begin clr = 1'b0; load = 1'b0; end
    check("clr_beats_load", now_t(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
